proc_control: RTL and testbench



---
 rtl/proc_control.sv | 151 +++++++++++++++
 tb/tb_proc_control.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/proc_control.sv
// proc_control: multicycle control unit for the 16-bit datapath.
// Sequences fetch/execute through timesteps T0..T3 and decodes the 9-bit
// instruction (III XXX YYY) into register load enables, bus-driver selects
// and the ALU operation. Every output is a combinational decode of the
// timestep, IR and GNZ, and is forced low while Resetn is asserted.
//
// Build option: define PROC_MVNZ_EN to execute opcode 100 as mvnz
// (conditional move on G non-zero). Without it, opcode 100 is a NOP and
// GNZ is ignored.
//
// Handshake: Run is a level request sampled only in T0; when high in T0,
// IRin loads the instruction on the closing edge and execution starts.
// Done marks the final cycle of an instruction; with Run held high the
// next cycle is T0 fetching the following instruction.

module proc_control (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       Run,
   input  logic [8:0] IR,
   input  logic       GNZ,
   output logic       IRin,
   output logic [7:0] Rin,
   output logic [7:0] Rout,
   output logic       DINout,
   output logic       Gout,
   output logic       Ain,
   output logic       Gin,
   output logic       AddSub,
   output logic       Done,
   output logic [1:0] tstep
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } tstep_t;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef PROC_MVNZ_EN
   localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

   tstep_t     state;
   tstep_t     next_state;
   logic [2:0] opcode;
   logic [7:0] x_sel;
   logic [7:0] y_sel;

`ifndef PROC_MVNZ_EN
   // GNZ only matters for mvnz; keep it referenced so the port stays tidy.
   logic unused_gnz;
   assign unused_gnz = GNZ;
`endif

   assign opcode = IR[8:6];
   assign x_sel  = 8'b0000_0001 << IR[5:3];
   assign y_sel  = 8'b0000_0001 << IR[2:0];
   assign tstep  = state;

   // Timestep register; reset abandons any instruction in flight.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= T0;
      end else begin
         state <= next_state;
      end
   end

   // Output and next-timestep decode; everything held low during reset.
   always_comb begin
      IRin       = 1'b0;
      Rin        = 8'b0;
      Rout       = 8'b0;
      DINout     = 1'b0;
      Gout       = 1'b0;
      Ain        = 1'b0;
      Gin        = 1'b0;
      AddSub     = 1'b0;
      Done       = 1'b0;
      next_state = T0;
      case (state)
         T0: begin
            IRin       = Run;
            next_state = Run ? T1 : T0;
         end
         T1: begin
            case (opcode)
               OP_MV: begin
                  Rout = y_sel;
                  Rin  = x_sel;
                  Done = 1'b1;
               end
               OP_MVI: begin
                  DINout = 1'b1;
                  Rin    = x_sel;
                  Done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  Rout       = x_sel;
                  Ain        = 1'b1;
                  next_state = T2;
               end
`ifdef PROC_MVNZ_EN
               OP_MVNZ: begin
                  Done = 1'b1;
                  if (GNZ) begin
                     Rout = y_sel;
                     Rin  = x_sel;
                  end
               end
`endif
               default: begin
                  Done = 1'b1;
               end
            endcase
         end
         T2: begin
            Rout       = y_sel;
            Gin        = 1'b1;
            AddSub     = IR[6];
            next_state = T3;
         end
         T3: begin
            Gout = 1'b1;
            Rin  = x_sel;
            Done = 1'b1;
         end
         default: begin
            next_state = T0;
         end
      endcase
      if (!Resetn) begin
         IRin   = 1'b0;
         Rin    = 8'b0;
         Rout   = 8'b0;
         DINout = 1'b0;
         Gout   = 1'b0;
         Ain    = 1'b0;
         Gin    = 1'b0;
         AddSub = 1'b0;
         Done   = 1'b0;
      end
   end

endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: directed bench for proc_control. A small IR register is
// modelled here so the instruction is loaded on the IRin edge like the
// real datapath. Expected output vectors are written out by hand.

module tb_proc_control;

   logic       Clock;
   logic       Resetn;
   logic       Run;
   logic [8:0] IR;
   logic       GNZ;
   logic       IRin;
   logic [7:0] Rin;
   logic [7:0] Rout;
   logic       DINout;
   logic       Gout;
   logic       Ain;
   logic       Gin;
   logic       AddSub;
   logic       Done;
   logic [1:0] tstep;

   logic [8:0] instr;
   int         checks = 0;
   int         errors = 0;

   localparam logic [24:0] IDLE = 25'd0;

   proc_control dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Run    (Run),
      .IR     (IR),
      .GNZ    (GNZ),
      .IRin   (IRin),
      .Rin    (Rin),
      .Rout   (Rout),
      .DINout (DINout),
      .Gout   (Gout),
      .Ain    (Ain),
      .Gin    (Gin),
      .AddSub (AddSub),
      .Done   (Done),
      .tstep  (tstep)
   );

   // Clock and reset-facing setup
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Datapath instruction register, loaded from instr when IRin is high
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) IR <= 9'd0;
      else if (IRin) IR <= instr;
   end

   // Build an expected vector: {tstep, IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done}
   function automatic logic [24:0] ev(input logic irin, input logic [7:0] rin,
                                      input logic [7:0] rout, input logic din,
                                      input logic gout, input logic ain,
                                      input logic gin, input logic addsub,
                                      input logic done, input logic [1:0] ts);
      return {ts, irin, rin, rout, din, gout, ain, gin, addsub, done};
   endfunction

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   // Compare all outputs plus the bus and Rin one-hot invariants
   task automatic check(input string tag, input logic [24:0] exp);
      logic [24:0] obs;
      #1;
      obs = {tstep, IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      checks++;
      assert ($onehot0({Rout, DINout, Gout}) === 1'b1) else begin
         errors++;
         $error("FAIL %s_bus observed=%b expected=onehot0", tag, {Rout, DINout, Gout});
      end
      checks++;
      assert ($onehot0(Rin) === 1'b1) else begin
         errors++;
         $error("FAIL %s_rin observed=%b expected=onehot0", tag, Rin);
      end
   endtask

   initial begin
      Resetn = 1'b0;
      Run    = 1'b1;
      GNZ    = 1'b0;
      instr  = 9'd0;

      // Reset held: outputs low even with Run high
      cyc(); check("rst_hold0", IDLE);
      cyc(); check("rst_hold1", IDLE);
      Run = 1'b0; Resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(); check("idle", IDLE);
      end

      // mvi R2
      instr = 9'b001_010_000; Run = 1'b1;
      check("mvi_t0", ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
      cyc(); Run = 1'b0;
      check("mvi_t1", ev(0, 8'b0000_0100, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1));
      cyc(); check("mvi_end", IDLE);

      // sub R1,R6 (Run dropped after fetch)
      instr = 9'b011_001_110; Run = 1'b1;
      check("sub_t0", ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
      cyc(); Run = 1'b0;
      check("sub_t1", ev(0, 8'h00, 8'b0000_0010, 0, 0, 1, 0, 0, 0, 2'd1));
      cyc(); check("sub_t2", ev(0, 8'h00, 8'b0100_0000, 0, 0, 0, 1, 1, 0, 2'd2));
      cyc(); check("sub_t3", ev(0, 8'b0000_0010, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3));
      cyc(); check("sub_end", IDLE);

      // mv R3,R3
      instr = 9'b000_011_011; Run = 1'b1;
      cyc(); Run = 1'b0;
      check("mv33_t1", ev(0, 8'b0000_1000, 8'b0000_1000, 0, 0, 0, 0, 0, 1, 2'd1));
      cyc(); check("mv33_end", IDLE);

      // Undefined opcode 111 is a NOP
      instr = 9'b111_101_010; Run = 1'b1;
      cyc(); Run = 1'b0;
      check("nop_t1", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1));
      cyc(); check("nop_end", IDLE);

      // mvnz R4,R5 with GNZ=0
      instr = 9'b100_100_101; Run = 1'b1; GNZ = 1'b0;
      cyc(); Run = 1'b0;
      check("mvnz_g0", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1));
      cyc();
      // mvnz R4,R5 with GNZ=1
      Run = 1'b1; GNZ = 1'b1;
      cyc(); Run = 1'b0;
`ifdef PROC_MVNZ_EN
      check("mvnz_g1", ev(0, 8'b0001_0000, 8'b0010_0000, 0, 0, 0, 0, 0, 1, 2'd1));
`else
      check("mvnz_g1", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1));
`endif
      cyc(); GNZ = 1'b0; check("mvnz_end", IDLE);

      // add R0,R1 interrupted by reset in T2
      instr = 9'b010_000_001; Run = 1'b1;
      cyc(); Run = 1'b0;
      check("add_t1", ev(0, 8'h00, 8'b0000_0001, 0, 0, 1, 0, 0, 0, 2'd1));
      cyc(); check("add_t2", ev(0, 8'h00, 8'b0000_0010, 0, 0, 0, 1, 0, 0, 2'd2));
      Resetn = 1'b0;
      check("add_rst", IDLE);
      cyc(); Resetn = 1'b1;
      check("add_rel0", IDLE);
      cyc(); check("add_rel1", IDLE);
      cyc(); check("add_rel2", IDLE);

      // Back-to-back: mv R1,R2 ; add R5,R1 ; mvi R7 with Run held
      instr = 9'b000_001_010; Run = 1'b1;
      check("b2b_c1", ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
      cyc(); instr = 9'b010_101_001;
      check("b2b_c2", ev(0, 8'b0000_0010, 8'b0000_0100, 0, 0, 0, 0, 0, 1, 2'd1));
      cyc(); check("b2b_c3", ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
      cyc(); instr = 9'b001_111_000;
      check("b2b_c4", ev(0, 8'h00, 8'b0010_0000, 0, 0, 1, 0, 0, 0, 2'd1));
      cyc(); check("b2b_c5", ev(0, 8'h00, 8'b0000_0010, 0, 0, 0, 1, 0, 0, 2'd2));
      cyc(); check("b2b_c6", ev(0, 8'b0010_0000, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3));
      cyc(); check("b2b_c7", ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
      cyc(); Run = 1'b0;
      check("b2b_c8", ev(0, 8'b1000_0000, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1));
      cyc(); check("b2b_end", IDLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
